// File: rtl/alu_cu_pkg.sv
// alu_cu_pkg: shared definitions for the ALU sequencing control unit.
//   - state_t         : IDLE -> READ -> EXEC -> WB sequencing states
//   - CLS_*           : opcode class encodings held in opcode[5:4]
//   - instruction field offsets for the 18-bit packed instruction
//   - bit positions of C/Z/N inside the 3-bit flag register
//   - op_class()      : extracts the class bits from an opcode
package alu_cu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [1:0] CLS_ILLEGAL = 2'b00;
    localparam logic [1:0] CLS_ARITH   = 2'b01;
    localparam logic [1:0] CLS_REL     = 2'b10;
    localparam logic [1:0] CLS_SHIFT   = 2'b11;

    // instr = {opcode[17:12], rd[11:8], rs1[7:4], rs2[3:0]}
    localparam int INSTR_W = 18;
    localparam int OP_W    = 6;
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;
    localparam int FLD_W   = 4;

    // flags = {C, Z, N}
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    function automatic logic [1:0] op_class(input logic [OP_W-1:0] op);
        return op[5:4];
    endfunction

endpackage

// File: rtl/alu_cu_regfile.sv
// alu_cu_regfile: REGS x XLEN register file for the ALU control unit.
// r0 has no storage and always reads as zero; writes to it are dropped.
// Ports:
//   clk, rst_n        clock; asynchronous active-low clear of every register
//   rd_en             capture both read ports on this edge
//   ra1/ra2           read addresses; rd1/rd2 hold the captured values
//                     until the next rd_en (they are the ALU operand regs)
//   we/wa/wd          single write port
//   dbg_addr/dbg_data combinational debug read
module alu_cu_regfile #(
    parameter int REGS = 16,
    parameter int XLEN = 32,
    parameter int AW   = $clog2(REGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_en,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    logic [XLEN-1:0] r_regs [1:REGS-1];
    logic [XLEN-1:0] r_rd1;
    logic [XLEN-1:0] r_rd2;

    // Address 0 falls through the loop and yields zero.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        for (int i = 1; i < REGS; i++) begin
            if (a == AW'(i)) v = r_regs[i];
        end
        return v;
    endfunction

    genvar gi;
    generate
        for (gi = 1; gi < REGS; gi++) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_regs[gi] <= '0;
                end else if (we && (wa == AW'(gi))) begin
                    r_regs[gi] <= wd;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd1 <= '0;
            r_rd2 <= '0;
        end else if (rd_en) begin
            r_rd1 <= read_port(ra1);
            r_rd2 <= read_port(ra2);
        end
    end

    assign rd1      = r_rd1;
    assign rd2      = r_rd2;
    assign dbg_data = read_port(dbg_addr);

endmodule

// File: rtl/alu_ctrl_unit.sv
// alu_ctrl_unit: sequences one instruction at a time through an external
// 32-bit ALU: READ operands -> EXEC (ALU settles, result sampled) -> WB.
// Optional feature macro: ALU_CU_CARRY_CHAIN_EN -- when defined, alu_cin
// carries the stored C flag (multiword add/sub); otherwise alu_cin is 0.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_valid/instr_ready    instruction handshake (ready only in IDLE)
//   instr[17:0]                {opcode, rd, rs1, rs2}
//   alu_a/alu_b/alu_op/alu_cin registered operands/opcode, carry-in to ALU
//   alu_ans/cout/z/n           ALU outputs, sampled at the end of EXEC
//   done/err                   one-cycle pulses in WB (legal / illegal class)
//   flags                      {C, Z, N}
//   dbg_addr/dbg_data          combinational register-file peek
module alu_ctrl_unit
    import alu_cu_pkg::*;
#(
    parameter int REGS = 16,
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    alu_a,
    output logic [XLEN-1:0]    alu_b,
    output logic [OP_W-1:0]    alu_op,
    output logic               alu_cin,
    input  logic [XLEN-1:0]    alu_ans,
    input  logic               alu_cout,
    input  logic               alu_z,
    input  logic               alu_n,
    output logic               done,
    output logic               err,
    output logic [2:0]         flags,
    input  logic [FLD_W-1:0]   dbg_addr,
    output logic [XLEN-1:0]    dbg_data
);

    state_t             r_state;
    state_t             w_state_next;
    logic [INSTR_W-1:0] r_instr;
    logic [OP_W-1:0]    r_alu_op;
    logic [XLEN-1:0]    r_res;
    logic               r_cout;
    logic               r_z;
    logic               r_n;
    logic [2:0]         r_flags;
    logic               w_rd_en;
    logic               w_we;

    logic [OP_W-1:0]  w_opcode;
    logic [FLD_W-1:0] w_rd;
    logic [FLD_W-1:0] w_rs1;
    logic [FLD_W-1:0] w_rs2;
    logic [1:0]       w_cls;

    assign w_opcode = r_instr[OP_LSB  +: OP_W];
    assign w_rd     = r_instr[RD_LSB  +: FLD_W];
    assign w_rs1    = r_instr[RS1_LSB +: FLD_W];
    assign w_rs2    = r_instr[RS2_LSB +: FLD_W];
    assign w_cls    = op_class(w_opcode);

    always_comb begin
        w_state_next = r_state;
        instr_ready  = 1'b0;
        w_rd_en      = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (r_state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) w_state_next = READ;
            end
            READ: begin
                w_rd_en      = 1'b1;
                w_state_next = EXEC;
            end
            EXEC: w_state_next = WB;
            WB: begin
                if (w_cls == CLS_ILLEGAL) err  = 1'b1;
                else                      done = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // rd == 0 still completes and updates flags; only the write is dropped.
    assign w_we = done && (w_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_instr  <= '0;
            r_alu_op <= '0;
            r_res    <= '0;
            r_cout   <= 1'b0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_flags  <= '0;
        end else begin
            r_state <= w_state_next;
            if (instr_valid && instr_ready) r_instr <= instr;
            if (r_state == READ) r_alu_op <= w_opcode;
            if (r_state == EXEC) begin
                r_res  <= alu_ans;
                r_cout <= alu_cout;
                r_z    <= alu_z;
                r_n    <= alu_n;
            end
            if (done) begin
                // Only arithmetic ops own the carry; others keep it intact
                // so a carry chain survives intervening compares/shifts.
                r_flags[FLAG_C] <= (w_cls == CLS_ARITH) ? r_cout : r_flags[FLAG_C];
                r_flags[FLAG_Z] <= r_z;
                r_flags[FLAG_N] <= r_n;
            end
        end
    end

    alu_cu_regfile #(
        .REGS (REGS),
        .XLEN (XLEN),
        .AW   (FLD_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (w_rd_en),
        .ra1      (w_rs1),
        .ra2      (w_rs2),
        .rd1      (alu_a),
        .rd2      (alu_b),
        .we       (w_we),
        .wa       (w_rd),
        .wd       (r_res),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign alu_op = r_alu_op;
    assign flags  = r_flags;

`ifdef ALU_CU_CARRY_CHAIN_EN
    assign alu_cin = r_flags[FLAG_C];
`else
    assign alu_cin = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// tb_alu_ctrl_unit: directed-vector bench for alu_ctrl_unit with a
// behavioural ALU on the alu_* ports. The driver pushes hand-computed
// expectations into a queue; a monitor pops one per done/err pulse and
// checks pulse type, latency, written register (via dbg port) and flags.
// Behavioural ALU opcodes: 010000 add(+cin), 010001 sub(-cin, C=borrow),
// 010010 inc, 100000 unsigned less-than (cout=1), 110000 shl (cout=0).
module tb_alu_ctrl_unit;

    localparam logic [5:0] OP_ADD  = 6'b010000;
    localparam logic [5:0] OP_SUB  = 6'b010001;
    localparam logic [5:0] OP_INC  = 6'b010010;
    localparam logic [5:0] OP_SLTU = 6'b100000;
    localparam logic [5:0] OP_SHL  = 6'b110000;
    localparam logic [5:0] OP_ILL  = 6'b000011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [17:0] instr;
    logic [31:0] alu_a, alu_b, alu_ans;
    logic [5:0]  alu_op;
    logic        alu_cin, alu_cout, alu_z, alu_n;
    logic        done, err;
    logic [2:0]  flags;
    logic [3:0]  dbg_addr, main_addr, mon_addr;
    logic        sweep_mode;
    logic [31:0] dbg_data;

    typedef struct {
        string       tag;
        bit          is_done;
        logic [3:0]  rd;
        logic [31:0] val;
        logic [2:0]  fl;
        int          t_acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign dbg_addr = sweep_mode ? main_addr : mon_addr;

    alu_ctrl_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_cin     (alu_cin),
        .alu_ans     (alu_ans),
        .alu_cout    (alu_cout),
        .alu_z       (alu_z),
        .alu_n       (alu_n),
        .done        (done),
        .err         (err),
        .flags       (flags),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Behavioural ALU
    always_comb begin
        alu_ans  = '0;
        alu_cout = 1'b0;
        case (alu_op[5:4])
            2'b01: begin
                case (alu_op[3:0])
                    4'h0:    {alu_cout, alu_ans} = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
                    4'h1:    {alu_cout, alu_ans} = {1'b0, alu_a} - {1'b0, alu_b} - {32'd0, alu_cin};
                    4'h2:    {alu_cout, alu_ans} = {1'b0, alu_a} + 33'd1;
                    default: alu_ans = '0;
                endcase
            end
            2'b10: begin
                alu_ans  = (alu_a < alu_b) ? 32'd1 : 32'd0;
                alu_cout = 1'b1;
            end
            2'b11: begin
                alu_ans  = alu_a << alu_b[4:0];
                alu_cout = 1'b0;
            end
            default: begin
                alu_ans  = 32'hDEAD_BEEF;
                alu_cout = 1'b1;
            end
        endcase
        alu_z = (alu_ans == 32'd0);
        alu_n = alu_ans[31];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
        end
    endtask

    task automatic sweep_zero(input string tag);
        sweep_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            main_addr = 4'(i);
            #1;
            chk($sformatf("%s r%0d", tag, i), dbg_data, 32'd0);
        end
        sweep_mode = 1'b0;
    endtask

    task automatic issue(input string tag, input logic [5:0] op, input logic [3:0] rd,
                         input logic [3:0] rs1, input logic [3:0] rs2, input bit is_done,
                         input logic [31:0] val, input logic [2:0] fl);
        exp_t e;
        int   w;
        w = 0;
        while (!instr_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        e.tag = tag; e.is_done = is_done; e.rd = rd; e.val = val; e.fl = fl; e.t_acc = cyc;
        q.push_back(e);
        instr       = {op, rd, rs1, rs2};
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        // Junk held while busy must be ignored (would write r15 if taken).
        instr = {OP_INC, 4'hF, 4'h0, 4'h0};
        @(negedge clk);
        w = 0;
        while (!instr_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " ready_lat"}, 32'(cyc - e.t_acc), 32'd4);
        instr_valid = 1'b0;
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        mon_addr = 4'd0;
        forever begin
            @(negedge clk);
            if (rst_n && (done || err)) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL stray_pulse: done=%0b err=%0b with nothing outstanding", done, err);
                end else begin
                    e = q.pop_front();
                    chk({e.tag, " done"}, 32'(done), 32'(e.is_done));
                    chk({e.tag, " err"}, 32'(err), 32'(!e.is_done));
                    chk({e.tag, " latency"}, 32'(cyc - e.t_acc), 32'd3);
                    mon_addr = e.rd;
                    @(negedge clk);
                    chk({e.tag, " pulse_width"}, 32'(done | err), 32'd0);
                    chk({e.tag, " rd_value"}, dbg_data, e.val);
                    chk({e.tag, " flags"}, 32'(flags), 32'(e.fl));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
        sweep_mode = 1'b1; main_addr = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset ready", 32'(instr_ready), 32'd1);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset flags", 32'(flags), 32'd0);
        chk("reset alu_a", alu_a, 32'd0);
        chk("reset alu_op", 32'(alu_op), 32'd0);
        sweep_zero("reset");

        // Build constants through an add chain; flags are {C,Z,N}.
        issue("inc r1",     OP_INC,  4'd1,  4'd0,  4'd0, 1'b1, 32'd1,  3'b000);
        issue("add r2",     OP_ADD,  4'd2,  4'd1,  4'd1, 1'b1, 32'd2,  3'b000);
        issue("add r6",     OP_ADD,  4'd6,  4'd2,  4'd2, 1'b1, 32'd4,  3'b000);
        issue("add r1=5",   OP_ADD,  4'd1,  4'd6,  4'd1, 1'b1, 32'd5,  3'b000);
        issue("add r2=7",   OP_ADD,  4'd2,  4'd1,  4'd2, 1'b1, 32'd7,  3'b000);
        issue("add r3=12",  OP_ADD,  4'd3,  4'd1,  4'd2, 1'b1, 32'd12, 3'b000);
        issue("inc r7",     OP_INC,  4'd7,  4'd0,  4'd0, 1'b1, 32'd1,  3'b000);
        issue("inc r14",    OP_INC,  4'd14, 4'd7,  4'd0, 1'b1, 32'd2,  3'b000);
        issue("add r14=3",  OP_ADD,  4'd14, 4'd14, 4'd7, 1'b1, 32'd3,  3'b000);
        issue("sub r1=-1",  OP_SUB,  4'd1,  4'd0,  4'd7, 1'b1, 32'hFFFF_FFFF, 3'b101);
        issue("inc r2=1",   OP_INC,  4'd2,  4'd0,  4'd0, 1'b1, 32'd1,  3'b000);
        issue("add r4 wrap", OP_ADD, 4'd4,  4'd1,  4'd2, 1'b1, 32'd0,  3'b110);
`ifdef ALU_CU_CARRY_CHAIN_EN
        issue("adc r5",     OP_ADD,  4'd5,  4'd1,  4'd0, 1'b1, 32'd0,  3'b110);
`else
        issue("adc r5",     OP_ADD,  4'd5,  4'd1,  4'd0, 1'b1, 32'hFFFF_FFFF, 3'b001);
`endif
        issue("inc r8",     OP_INC,  4'd8,  4'd0,  4'd0, 1'b1, 32'd1,  3'b000);
        issue("sltu r9",    OP_SLTU, 4'd9,  4'd7,  4'd1, 1'b1, 32'd1,  3'b000);
        issue("add r11 C1", OP_ADD,  4'd11, 4'd1,  4'd2, 1'b1, 32'd0,  3'b110);
        issue("shl r10",    OP_SHL,  4'd10, 4'd1,  4'd7, 1'b1, 32'hFFFF_FFFE, 3'b101);
        issue("illegal",    OP_ILL,  4'd13, 4'd1,  4'd2, 1'b0, 32'd0,  3'b101);
        issue("add rd0",    OP_ADD,  4'd0,  4'd14, 4'd6, 1'b1, 32'd0,  3'b000);

        w = 0;
        while (q.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("queue drained", 32'(q.size()), 32'd0);
        sweep_mode = 1'b1; main_addr = 4'd15; #1;
        chk("junk r15 ignored", dbg_data, 32'd0);
        main_addr = 4'd3; #1;
        chk("r3 kept", dbg_data, 32'd12);
        sweep_mode = 1'b0;

        // Abort an instruction with reset while it is in EXEC.
        @(negedge clk);
        instr = {OP_ADD, 4'd12, 4'd1, 4'd2};
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort ready", 32'(instr_ready), 32'd1);
        chk("abort done", 32'(done), 32'd0);
        chk("abort flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post-abort ready", 32'(instr_ready), 32'd1);
        chk("post-abort flags", 32'(flags), 32'd0);
        sweep_zero("abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_unit.md
# alu_ctrl_unit

Sequencing control unit that sits directly upstream of the 32-bit ALU. It accepts one packed instruction at a time over a valid/ready handshake and reads two operands from an internal 16x32 register file. It drives the ALU operand, opcode and carry-in inputs, then captures the ALU result, carry/borrow and Z/N flags. Results are written back to the register file and flag register, and completion is reported with a one-cycle pulse.

## Interface
- REGS, 16: register-file depth; r0 reads as zero.
- XLEN, 32: datapath width; must match the ALU.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  unit can accept; high only in IDLE.
- instr  in  18  {opcode[17:12], rd[11:8], rs1[7:4], rs2[3:0]}.
- alu_a, alu_b  out  XLEN  registered operands to ALU.
- alu_op  out  6  registered opcode to ALU.
- alu_cin  out  1  carry/borrow-in to ALU.
- alu_ans  in  XLEN  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_cout, alu_z, alu_n  in  1  ALU carry/borrow-out, zero, negative.
- done  out  1  one-cycle pulse on writeback cycle.
- err  out  1  one-cycle pulse for illegal opcode class.
- flags  out  3  {C, Z, N} flag register.
- dbg_addr  in  4  debug read address.
- dbg_data  out  XLEN  combinational read of register dbg_addr (0 for r0).

## Operation
- States: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE: instr_ready=1. On instr_valid&&instr_ready latch instr, go READ.
- READ: alu_a<=reg[rs1], alu_b<=reg[rs2], alu_op<=opcode. Go EXEC.
- EXEC: ALU settles and unit samples alu_ans/alu_cout/alu_z/alu_n into result registers at end of cycle. Go WB.
- WB: decode opcode[5:4]:
  - 01 arithmetic: write rd, update C,Z,N.
  - 10 relational: write rd, update Z,N; C held.
  - 11 shift: write rd, update Z,N; C held.
  - 00 illegal: no write, flags held, err=1, done=0.
  - Else done=1. Go IDLE.
- rd=0: write suppressed; flags still updated; done still pulses.
- Operand read in READ sees any write committed by the previous instruction's WB (no hazard possible, single issue).
- Reset: state=IDLE, all registers incl. regfile =0, alu_a/alu_b=0, alu_op=0, flags=0, done=0, err=0, instr_ready=1 after reset release. Reset mid-operation aborts instruction; no writeback.
- instr held or changed while not ready: ignored.

## Timing
- Accept at edge T; READ in cycle T+1, EXEC in T+2, WB in T+3; done/err high during T+3; register write and flags visible from T+4.
- instr_ready re-asserts in cycle T+4; max throughput one instruction per 4 cycles.
- alu_a/alu_b/alu_op stable from T+2 until next READ.
- dbg_data combinational, zero latency.

## Configuration
- ALU_CU_CARRY_CHAIN_EN defined: alu_cin = stored C flag (enables multiword add-with-carry / subtract-with-borrow).
- Not defined: alu_cin tied 0; C flag still recorded and visible on flags.

## Structure
- Package alu_cu_pkg: state enum (IDLE, READ, EXEC, WB), opcode-class constants (CLS_ILLEGAL=2'b00, CLS_ARITH=2'b01, CLS_REL=2'b10, CLS_SHIFT=2'b11), instr field offsets, flag bit indices.
- Sub-module alu_cu_regfile: REGS x XLEN, two synchronous-latched read ports, one write port, debug read port, r0 hardwired zero, async active-low clear.
- Bench uses a behavioural ALU model on the alu_* ports.

## Test plan
- Reset then idle: flags=0, dbg_data=0 for all addresses, instr_ready=1, done=0.
- Preload r1=5, r2=7 via add chain; issue opcode 010000 rd=3 rs1=1 rs2=2 -> done at T+3, r3=12, flags C=0,Z=0,N=0, instr_ready back at T+4.
- r1=0xFFFFFFFF, r2=1, add into r4 -> r4=0, C=1, Z=1; next add r1+r0 into r5 with ALU_CU_CARRY_CHAIN_EN -> r5=0 (0xFFFFFFFF+0+1), without macro -> r5=0xFFFFFFFF.
- Opcode 000011 -> err pulse at T+3, no done, no register or flag change.
- rd=0 add of 3+4 -> done pulses, r0 still reads 0, Z=0.
- Assert rst_n low during EXEC -> no writeback, state IDLE, all registers 0.
